// File: rtl/rv32_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rv32_pkg: opcodes, bubble word and fetch-stage encodings  rev 1.0 |
// +-----------------------------------------------------------------+
package rv32_pkg;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT = 2'b00,
        FS_RUN  = 2'b01,
        FS_HALT = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'b00,
        PC_INC      = 2'b01,
        PC_REDIRECT = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_BUBBLE = 2'b01,
        IFID_LOAD   = 2'b10
    } ifid_op_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_stage_if: control, imem and IF/ID bundle of fetch  rev 1.0  |
// +-----------------------------------------------------------------+
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    modport master (
        input  stall, flush, redirect_pc, imem_rdata,
        output imem_addr, if_id_pc, if_id_inst, if_id_valid,
               opcode, rd_addr, rs1_addr, rs2_addr, halted,
               fetch_cnt, stall_cnt
    );

    modport slave (
        output stall, flush, redirect_pc, imem_rdata,
        input  imem_addr, if_id_pc, if_id_inst, if_id_valid,
               opcode, rd_addr, rs1_addr, rs2_addr, halted,
               fetch_cnt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_pc_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pc_gen: program counter with hold / +4 / redirect select rev 1.0 |
// +-----------------------------------------------------------------+
module pc_gen
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire pc_sel_e     pc_sel,
    input  wire logic [31:0] redirect_pc,
    output logic [31:0]      pc
);

    logic [31:0] pc_next;

    // Redirect targets are forced word-aligned.
    always_comb begin
        pc_next = pc;
        unique case (pc_sel)
            PC_INC:      pc_next = pc + 32'd4;
            PC_REDIRECT: pc_next = redirect_pc & ~32'h0000_0003;
            default:     pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= pc_next;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_stage: IF stage + IF/ID register, BOOT/RUN/HALT FSM rev 1.0 |
// | Optional perf counters: define FETCH_PERF_CNT_EN                 |
// +-----------------------------------------------------------------+
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv32_pkg::NOP_INST
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e state, state_next;
    pc_sel_e      pc_sel;
    ifid_op_e     ifid_op;
    logic [31:0]  pc;
    logic [31:0]  ifid_pc;
    logic [31:0]  ifid_inst;
    logic         ifid_valid;

    pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .redirect_pc (bus.redirect_pc),
        .pc          (pc)
    );

    // Flush outranks stall; stall and flush are both ignored in BOOT.
    always_comb begin
        state_next = state;
        pc_sel     = PC_HOLD;
        ifid_op    = IFID_HOLD;
        unique case (state)
            FS_BOOT: begin
                state_next = FS_RUN;
                ifid_op    = IFID_BUBBLE;
            end
            FS_RUN: begin
                if (bus.flush) begin
                    pc_sel  = PC_REDIRECT;
                    ifid_op = IFID_BUBBLE;
                end else if (!bus.stall) begin
                    pc_sel  = PC_INC;
                    ifid_op = IFID_LOAD;
                    if (bus.imem_rdata[6:0] == OP_SYSTEM) state_next = FS_HALT;
                end
            end
            FS_HALT: begin
                ifid_op = IFID_BUBBLE;
                if (bus.flush) begin
                    pc_sel     = PC_REDIRECT;
                    state_next = FS_RUN;
                end
            end
            default: begin
                state_next = FS_BOOT;
                ifid_op    = IFID_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FS_BOOT;
            ifid_pc    <= 32'd0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else begin
            state <= state_next;
            unique case (ifid_op)
                IFID_BUBBLE: begin
                    ifid_pc    <= 32'd0;
                    ifid_inst  <= NOP_INST;
                    ifid_valid <= 1'b0;
                end
                IFID_LOAD: begin
                    ifid_pc    <= pc;
                    ifid_inst  <= bus.imem_rdata;
                    ifid_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (ifid_op == IFID_LOAD) fetch_cnt <= fetch_cnt + 32'd1;
            if (state == FS_RUN && bus.stall && !bus.flush) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt;
    assign bus.stall_cnt = stall_cnt;
`else
    assign bus.fetch_cnt = 32'd0;
    assign bus.stall_cnt = 32'd0;
`endif

    assign bus.imem_addr   = pc;
    assign bus.if_id_pc    = ifid_pc;
    assign bus.if_id_inst  = ifid_inst;
    assign bus.if_id_valid = ifid_valid;
    assign bus.opcode      = ifid_inst[6:0];
    assign bus.rd_addr     = ifid_inst[11:7];
    assign bus.rs1_addr    = ifid_inst[19:15];
    assign bus.rs2_addr    = ifid_inst[24:20];
    assign bus.halted      = (state == FS_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fetch_stage: directed + random bench for fetch_stage   rev 1.0 |
// +-----------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] sys_addr;
    int          compared;
    int          mismatched;

    // Reference model state
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid;
    int          m_mode;   // 0 boot, 1 run, 2 halt
    logic [31:0] m_fcnt, m_scnt;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == sys_addr) return 32'h0000_0073;
        return {a[24:0] ^ 25'h1A5_5A5A, 7'b0010011};
    endfunction

    assign bus.imem_rdata = (bus.imem_addr == sys_addr) ? 32'h0000_0073
                          : {bus.imem_addr[24:0] ^ 25'h1A5_5A5A, 7'b0010011};

    // Advance one clock; the model applies the same inputs the DUT sees.
    task automatic tick();
        logic [31:0] w;
        w = mem_word(m_pc);
        if (!rst_n) begin
            m_pc = 32'd0; m_ifpc = 32'd0; m_inst = NOP; m_valid = 1'b0;
            m_mode = 0; m_fcnt = 32'd0; m_scnt = 32'd0;
        end else if (m_mode == 0) begin
            m_inst = NOP; m_valid = 1'b0; m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.flush) begin
                m_pc = {bus.redirect_pc[31:2], 2'b00}; m_inst = NOP; m_valid = 1'b0;
            end else if (bus.stall) begin
                m_scnt = m_scnt + 32'd1;
            end else begin
                m_ifpc = m_pc; m_inst = w; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_fcnt = m_fcnt + 32'd1;
                if (w[6:0] == 7'b1110011) m_mode = 2;
            end
        end else begin
            m_inst = NOP; m_valid = 1'b0;
            if (bus.flush) begin
                m_pc = {bus.redirect_pc[31:2], 2'b00}; m_mode = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_pc = 32'd0;
        repeat (3) tick();
        compared++;
        if ({bus.imem_addr, bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, bus.halted} !==
            {32'd0, 32'd0, NOP, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got addr=%h pc=%h inst=%h v=%b h=%b want 0/0/%h/0/0",
                     bus.imem_addr, bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, bus.halted, NOP);
        end
        compared++;
        if ({bus.fetch_cnt, bus.stall_cnt} !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", bus.fetch_cnt, bus.stall_cnt);
        end
        compared++;
        if (bus.opcode !== 7'b0010011) begin
            mismatched++;
            $display("FAIL reset_opcode: got %b want 0010011", bus.opcode);
        end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        tick();
        compared++;
        if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'd0) begin
            mismatched++;
            $display("FAIL boot_bubble: got v=%b addr=%h want 0/0", bus.if_id_valid, bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_inst} !==
                {1'b1, 32'(i * 4), mem_word(32'(i * 4))}) begin
                mismatched++;
                $display("FAIL seq_fetch%0d: got v=%b pc=%h inst=%h want 1/%h/%h", i,
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, 32'(i * 4), mem_word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++;
            if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.imem_addr} !==
                {1'b1, 32'd8, mem_word(32'd8), 32'd12}) begin
                mismatched++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h addr=%h want 1/8/%h/c", i,
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.imem_addr, mem_word(32'd8));
            end
        end
        bus.stall = 1'b0;
        tick();
        compared++;
        if (bus.if_id_pc !== 32'd12 || bus.if_id_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_resume: got pc=%h v=%b want c/1", bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_flush_over_stall();
        bus.stall = 1'b1; bus.flush = 1'b1; bus.redirect_pc = 32'h100;
        tick();
        bus.stall = 1'b0; bus.flush = 1'b0;
        compared++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== NOP || bus.imem_addr !== 32'h100) begin
            mismatched++;
            $display("FAIL flush_bubble: got v=%b inst=%h addr=%h want 0/%h/100",
                     bus.if_id_valid, bus.if_id_inst, bus.imem_addr, NOP);
        end
        tick();
        compared++;
        if (bus.if_id_pc !== 32'h100 || bus.if_id_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_target: got pc=%h v=%b want 100/1", bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_halt();
        bus.flush = 1'b1; bus.redirect_pc = 32'h10;
        tick();
        bus.flush = 1'b0; sys_addr = 32'h10;
        tick();
        compared++;
        if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.halted} !==
            {1'b1, 32'h10, 32'h0000_0073, 1'b1}) begin
            mismatched++;
            $display("FAIL halt_entry: got v=%b pc=%h inst=%h h=%b want 1/10/00000073/1",
                     bus.if_id_valid, bus.if_id_pc, bus.if_id_inst, bus.halted);
        end
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            compared++;
            if ({bus.if_id_valid, bus.if_id_inst, bus.halted, bus.imem_addr} !==
                {1'b0, NOP, 1'b1, 32'h14}) begin
                mismatched++;
                $display("FAIL halt_bubble%0d: got v=%b inst=%h h=%b addr=%h want 0/%h/1/14", i,
                         bus.if_id_valid, bus.if_id_inst, bus.halted, bus.imem_addr, NOP);
            end
        end
        bus.stall = 1'b0; bus.flush = 1'b1; bus.redirect_pc = 32'h40; sys_addr = 32'hFFFF_FFFF;
        tick();
        bus.flush = 1'b0;
        compared++;
        if (bus.halted !== 1'b0 || bus.if_id_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL halt_exit: got h=%b v=%b want 0/0", bus.halted, bus.if_id_valid);
        end
        tick();
        compared++;
        if (bus.if_id_pc !== 32'h40 || bus.if_id_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL halt_resume: got pc=%h v=%b want 40/1", bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_wrap();
        bus.flush = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        tick();
        bus.flush = 1'b0;
        compared++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            mismatched++;
            $display("FAIL wrap_align: got %h want fffffffc", bus.imem_addr);
        end
        tick();
        compared++;
        if (bus.if_id_pc !== 32'hFFFF_FFFC || bus.if_id_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL wrap_top: got pc=%h v=%b want fffffffc/1", bus.if_id_pc, bus.if_id_valid);
        end
        tick();
        compared++;
        if (bus.if_id_pc !== 32'd0 || bus.imem_addr !== 32'd4) begin
            mismatched++;
            $display("FAIL wrap_zero: got pc=%h addr=%h want 0/4", bus.if_id_pc, bus.imem_addr);
        end
    endtask

    task automatic test_counters();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1; bus.redirect_pc = 32'h200;
        tick();
        bus.stall = 1'b0; bus.flush = 1'b0;
        compared++;
        if (bus.imem_addr !== 32'd0 || bus.if_id_valid !== 1'b0 || bus.stall_cnt !== 32'd0) begin
            mismatched++;
            $display("FAIL boot_ignore: got addr=%h v=%b scnt=%h want 0/0/0",
                     bus.imem_addr, bus.if_id_valid, bus.stall_cnt);
        end
        repeat (5) tick();
        bus.stall = 1'b1;
        repeat (3) tick();
        bus.stall = 1'b0;
        compared++;
        if (bus.fetch_cnt !== (PERF ? 32'd5 : 32'd0) || bus.stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin
            mismatched++;
            $display("FAIL perf_cnt: got f=%0d s=%0d want f=%0d s=%0d", bus.fetch_cnt, bus.stall_cnt,
                     PERF ? 5 : 0, PERF ? 3 : 0);
        end
    endtask

    task automatic test_random();
        logic [87:0] exp_v, act_v;
        for (int n = 0; n < 400; n++) begin
            rst_n           = ($urandom_range(0, 99) >= 2);
            bus.stall       = ($urandom_range(0, 99) < 25);
            bus.flush       = ($urandom_range(0, 99) < 10);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : {20'd0, 12'($urandom)};
            if ($urandom_range(0, 19) == 0) sys_addr = m_pc + 32'($urandom_range(0, 7) * 4);
            tick();
            exp_v = {m_pc, m_valid, m_inst, (m_mode == 2), m_inst[6:0], m_inst[11:7],
                     m_inst[19:15], m_inst[24:20]};
            act_v = {bus.imem_addr, bus.if_id_valid, bus.if_id_inst, bus.halted, bus.opcode,
                     bus.rd_addr, bus.rs1_addr, bus.rs2_addr};
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("FAIL rand_state[%0d]: got %h want %h", n, act_v, exp_v);
            end
            if (m_valid) begin
                compared++;
                if (bus.if_id_pc !== m_ifpc) begin
                    mismatched++;
                    $display("FAIL rand_pc[%0d]: got %h want %h", n, bus.if_id_pc, m_ifpc);
                end
            end
            compared++;
            if (bus.fetch_cnt !== (PERF ? m_fcnt : 32'd0) || bus.stall_cnt !== (PERF ? m_scnt : 32'd0)) begin
                mismatched++;
                $display("FAIL rand_cnt[%0d]: got %h/%h want %h/%h", n, bus.fetch_cnt, bus.stall_cnt,
                         PERF ? m_fcnt : 32'd0, PERF ? m_scnt : 32'd0);
            end
        end
        rst_n = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        sys_addr   = 32'hFFFF_FFFF;
        m_pc = 32'd0; m_ifpc = 32'd0; m_inst = NOP; m_valid = 1'b0;
        m_mode = 0; m_fcnt = 32'd0; m_scnt = 32'd0;
        rst_n = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_pc = 32'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_flush_over_stall();
        test_halt();
        test_wrap();
        test_counters();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
